// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: memory geometry,
// length-header size and the loader state encoding.
package imem_loader_pkg;

    localparam int IMEM_ADDR_W = 9;
    localparam int IMEM_DATA_W = 16;
    localparam int IMEM_DEPTH  = 512;
    localparam int LEN_BYTES   = 2;

    typedef enum logic [3:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        BYTE_HI,
        BYTE_LO,
        WRITE,
        CHK,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/imem_loader.sv
// Instruction-memory loader: takes a byte stream (16-bit big-endian word
// count, then big-endian 16-bit words) over valid/ready and writes the words
// to consecutive memory addresses starting at BASE_ADDR, holding the CPU for
// the duration of the load.
// Optional build macro IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum
// byte that must match the XOR of all data bytes for the load to succeed.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = IMEM_ADDR_W,
    parameter int DATA_W    = IMEM_DATA_W,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    localparam int                CNT_W   = ADDR_W + 1;
    localparam logic [15:0]       MAX_LEN = 16'(1 << ADDR_W);
    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);

    state_t            state, state_nxt;
    logic [7:0]        len_hi, len_hi_nxt;
    logic [CNT_W-1:0]  len_q, len_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [DATA_W-1:0] wdata, wdata_nxt;
    logic [15:0]       len_word;
    logic              accept;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        chk, chk_nxt;
`endif

    assign accept     = in_valid && in_ready;
    assign len_word   = {len_hi, in_data};
    assign mem_wdata  = wdata;
    assign word_count = cnt;
    // Address is only meaningful during the write cycle; parked at zero otherwise.
    assign mem_addr   = mem_we ? (BASE + cnt[ADDR_W-1:0]) : '0;

    // Moore-style status outputs decoded straight from the state.
    always_comb begin
        in_ready = state inside {LEN_HI, LEN_LO, BYTE_HI, BYTE_LO, CHK};
        mem_we   = (state == WRITE);
        cpu_hold = !(state inside {IDLE, DONE, ERR});
        done     = (state == DONE);
        error    = (state == ERR);
    end

    // Next-state and datapath-update logic.
    always_comb begin
        // NOTE: every target gets a hold value first so no path can infer a latch.
        state_nxt  = state;
        len_hi_nxt = len_hi;
        len_nxt    = len_q;
        cnt_nxt    = cnt;
        wdata_nxt  = wdata;
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk_nxt    = chk;
`endif
        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_nxt = LEN_HI;
                    cnt_nxt   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    chk_nxt   = '0;
`endif
                end
            end
            LEN_HI: begin
                if (accept) begin
                    len_hi_nxt = in_data;
                    state_nxt  = LEN_LO;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    len_nxt = len_word[CNT_W-1:0];
                    if (len_word == '0)
                        state_nxt = DONE;
                    else if (len_word > MAX_LEN)
                        state_nxt = ERR;
                    else
                        state_nxt = BYTE_HI;
                end
            end
            BYTE_HI: begin
                if (accept) begin
                    wdata_nxt[DATA_W-1:DATA_W-8] = in_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    chk_nxt = chk ^ in_data;
`endif
                    state_nxt = BYTE_LO;
                end
            end
            BYTE_LO: begin
                if (accept) begin
                    wdata_nxt[7:0] = in_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    chk_nxt = chk ^ in_data;
`endif
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt_nxt == len_q)
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_nxt = CHK;
`else
                    state_nxt = DONE;
`endif
                else
                    state_nxt = BYTE_HI;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
                if (accept)
                    state_nxt = (in_data == chk) ? DONE : ERR;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any load in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            len_hi <= '0;
            len_q  <= '0;
            cnt    <= '0;
            wdata  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk    <= '0;
`endif
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            state  <= state_nxt;
            len_hi <= len_hi_nxt;
            len_q  <= len_nxt;
            cnt    <= cnt_nxt;
            wdata  <= wdata_nxt;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk    <= chk_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader. Two instances share one byte stream:
// one loads at base 0, the other at base 510 so every load also exercises
// address wrap. A behavioural model derives expected writes, flags and the
// final memory image from the stream contents.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int AW     = IMEM_ADDR_W;
    localparam int DW     = IMEM_DATA_W;
    localparam int BASE_B = 510;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;

    logic          ready_a, we_a, hold_a, done_a, error_a;
    logic [AW-1:0] addr_a;
    logic [DW-1:0] wdata_a;
    logic [AW:0]   wc_a;
    logic          ready_b, we_b, hold_b, done_b, error_b;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] wdata_b;
    logic [AW:0]   wc_b;

    imem_loader #(.ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(0)) dut_a (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(ready_a), .mem_addr(addr_a), .mem_wdata(wdata_a), .mem_we(we_a),
        .cpu_hold(hold_a), .done(done_a), .error(error_a), .word_count(wc_a)
    );

    imem_loader #(.ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(BASE_B)) dut_b (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(ready_b), .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_we(we_b),
        .cpu_hold(hold_b), .done(done_b), .error(error_b), .word_count(wc_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int c0 = 0;

    logic [DW-1:0] mem_a [IMEM_DEPTH];
    logic [DW-1:0] mem_b [IMEM_DEPTH];
    logic [DW-1:0] exp_a [IMEM_DEPTH];
    logic [DW-1:0] exp_b [IMEM_DEPTH];
    wr_t           wlog_a [$];
    wr_t           wlog_b [$];
    logic [DW-1:0] wq [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Memories capture on the falling edge, as the real instruction memory does.
    always @(negedge clk) begin
        if (we_a === 1'b1) begin
            mem_a[addr_a] = wdata_a;
            wlog_a.push_back('{addr: addr_a, data: wdata_a});
        end
        if (we_b === 1'b1) begin
            mem_b[addr_b] = wdata_b;
            wlog_b.push_back('{addr: addr_b, data: wdata_b});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        c0 = cyc;
        check("hold_after_start_a", 32'(hold_a), 32'd1);
        check("hold_after_start_b", 32'(hold_b), 32'd1);
    endtask

    // Offer one byte after an optional random gap; wait (bounded) for acceptance.
    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int gap;
        bit got;
        gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        got = 1'b0;
        repeat (gap) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ready_a === 1'b1 && ready_b === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check("byte_accepted", 32'(got), 32'd1);
        check("hold_while_loading", 32'({hold_a, hold_b}), 32'b11);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_end(output int lat);
        bit seen;
        seen = 1'b0;
        lat  = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_a === 1'b1 || error_a === 1'b1) begin
                seen = 1'b1;
                lat  = cyc - c0;
                break;
            end
        end
        check("load_finished", 32'(seen), 32'd1);
    endtask

    task automatic check_image(input string tag);
        int mism;
        mism = 0;
        for (int i = 0; i < IMEM_DEPTH; i++) begin
            if (mem_a[i] !== exp_a[i]) mism++;
            if (mem_b[i] !== exp_b[i]) mism++;
        end
        check(tag, 32'(mism), 32'd0);
    endtask

    // Run a full load with length header n and payload wq; the model decides
    // which words land where and how the load ends.
    task automatic run_load(input logic [15:0] n, input int gap_max, input bit corrupt);
        bit       valid;
        int       n_exp;
        int       lat;
        int       min_lat;
        logic     exp_done, exp_err;
        logic [7:0] ck;
        valid = (n != 16'd0) && (int'(n) <= IMEM_DEPTH);
        n_exp = valid ? int'(n) : 0;
        ck = 8'h00;
        wlog_a.delete();
        wlog_b.delete();

        do_start();
        send_byte(n[15:8], gap_max);
        send_byte(n[7:0], gap_max);
        for (int i = 0; i < n_exp; i++) begin
            send_byte(wq[i][15:8], gap_max);
            send_byte(wq[i][7:0], gap_max);
            ck = ck ^ wq[i][15:8] ^ wq[i][7:0];
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (valid) send_byte(ck ^ {7'd0, corrupt}, gap_max);
        exp_done = (n == 16'd0) || (valid && !corrupt);
        exp_err  = (int'(n) > IMEM_DEPTH) || (valid && corrupt);
        min_lat  = 2 + 3 * n_exp + (valid ? 1 : 0);
`else
        exp_done = (int'(n) <= IMEM_DEPTH);
        exp_err  = (int'(n) > IMEM_DEPTH);
        min_lat  = 2 + 3 * n_exp;
        if (corrupt) exp_done = exp_done;
`endif
        wait_end(lat);

        check("done_a", 32'(done_a), 32'(exp_done));
        check("error_a", 32'(error_a), 32'(exp_err));
        check("done_b", 32'(done_b), 32'(exp_done));
        check("error_b", 32'(error_b), 32'(exp_err));
        check("hold_released", 32'({hold_a, hold_b}), 32'd0);
        check("word_count_a", 32'(wc_a), 32'(n_exp));
        check("word_count_b", 32'(wc_b), 32'(n_exp));
        check("we_pulses_a", 32'(wlog_a.size()), 32'(n_exp));
        check("we_pulses_b", 32'(wlog_b.size()), 32'(n_exp));
        if (gap_max == 0 && valid)
            check("latency_min", 32'(lat >= min_lat), 32'd1);

        for (int i = 0; i < n_exp; i++) begin
            if (i < wlog_a.size())
                check("write_a", 32'(wlog_a[i]), 32'({AW'(i % IMEM_DEPTH), wq[i]}));
            if (i < wlog_b.size())
                check("write_b", 32'(wlog_b[i]), 32'({AW'((BASE_B + i) % IMEM_DEPTH), wq[i]}));
            exp_a[i % IMEM_DEPTH]            = wq[i];
            exp_b[(BASE_B + i) % IMEM_DEPTH] = wq[i];
        end
        check_image("mem_image");
        @(posedge clk);
        #1;
    endtask

    task automatic random_words(input int n);
        wq.delete();
        for (int i = 0; i < n; i++) wq.push_back(DW'($urandom));
    endtask

    initial begin
        for (int i = 0; i < IMEM_DEPTH; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
            exp_a[i] = '0;
            exp_b[i] = '0;
        end

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'({ready_a, ready_b}), 32'd0);
        check("rst_we", 32'({we_a, we_b}), 32'd0);
        check("rst_hold", 32'({hold_a, hold_b}), 32'd0);
        check("rst_flags", 32'({done_a, error_a, done_b, error_b}), 32'd0);
        check("rst_wc", 32'({wc_a, wc_b}), 32'd0);
        check("rst_addr", 32'({addr_a, addr_b}), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("idle_hold", 32'({hold_a, hold_b}), 32'd0);

        // Directed two-word load: 00 02 12 34 AB CD.
        wq.delete();
        wq.push_back(16'h1234);
        wq.push_back(16'hABCD);
        run_load(16'd2, 0, 1'b0);

        // Empty load and oversize load: no writes.
        wq.delete();
        run_load(16'h0000, 0, 1'b0);
        run_load(16'h0201, 0, 1'b0);

        // Four words: instance B writes 510, 511, 0, 1.
        random_words(4);
        run_load(16'd4, 0, 1'b0);

        // Sixteen words with random valid gaps.
        random_words(16);
        run_load(16'd16, 5, 1'b0);

        // Reset after three of eight words.
        random_words(8);
        wlog_a.delete();
        wlog_b.delete();
        do_start();
        send_byte(8'h00, 0);
        send_byte(8'h08, 0);
        for (int i = 0; i < 3; i++) begin
            send_byte(wq[i][15:8], 0);
            send_byte(wq[i][7:0], 0);
        end
        @(posedge clk);
        #1;
        check("wc_before_abort", 32'(wc_a), 32'd3);
        #2;
        rst = 1'b0;
        #1;
        check("abort_ready", 32'({ready_a, ready_b}), 32'd0);
        check("abort_we", 32'({we_a, we_b}), 32'd0);
        check("abort_hold", 32'({hold_a, hold_b}), 32'd0);
        check("abort_flags", 32'({done_a, error_a, done_b, error_b}), 32'd0);
        check("abort_wc", 32'({wc_a, wc_b}), 32'd0);
        check("abort_addr", 32'({addr_a, addr_b}), 32'd0);
        check("abort_wdata", 32'({wdata_a, wdata_b}), 32'd0);
        check("abort_writes", 32'(wlog_a.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            exp_a[i] = wq[i];
            exp_b[(BASE_B + i) % IMEM_DEPTH] = wq[i];
        end
        check_image("mem_after_abort");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        random_words(8);
        run_load(16'd8, 0, 1'b0);

        // Largest legal load fills the whole memory.
        random_words(IMEM_DEPTH);
        run_load(16'(IMEM_DEPTH), 0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // 00 01 12 34 26 succeeds; trailing 27 fails but keeps the word.
        wq.delete();
        wq.push_back(16'h1234);
        run_load(16'd1, 0, 1'b0);
        wq.delete();
        wq.push_back(16'h1234);
        run_load(16'd1, 0, 1'b1);
        check("chk_word_kept", 32'(mem_a[0]), 32'h1234);
        random_words(16);
        run_load(16'd16, 3, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer-side companion to the instruction memory.
- Receives a byte stream over a valid/ready handshake and assembles big-endian 16-bit instruction words.
- Drives the memory's address, write-data and write-enable port to load a program at runtime.
- Holds the CPU for the whole load and reports completion or error.

Parameters:
- ADDR_W, 9, instruction memory address width (512 words).
- DATA_W, 16, instruction word width; fixed at 2 bytes per word.
- BASE_ADDR, 0, first memory address written.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load; sampled only in IDLE/DONE/ERR.
- in_valid  in  1  byte-stream valid.
- in_data  in  8  byte-stream data.
- in_ready  out  1  loader can accept a byte this cycle.
- mem_addr  out  ADDR_W  to memory address input.
- mem_wdata  out  DATA_W  to memory data input.
- mem_we  out  1  to memory write enable.
- cpu_hold  out  1  high while loading; CPU must stall.
- done  out  1  sticky success flag.
- error  out  1  sticky failure flag.
- word_count  out  ADDR_W+1  words written so far.

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0. Reset mid-load aborts immediately. Words already written stay in memory.
- States: IDLE, LEN_HI, LEN_LO, BYTE_HI, BYTE_LO, WRITE, CHK (only with the optional feature), DONE, ERR.
- A byte is accepted only on a posedge with in_valid && in_ready.
- in_ready is 1 in LEN_HI, LEN_LO, BYTE_HI, BYTE_LO and CHK; 0 in every other state.
- IDLE/DONE/ERR on start:
  - go to LEN_HI; clear done, error, word_count.
  - cpu_hold=1 from the next cycle until DONE or ERR is entered.
- start is ignored in all other states.
- LEN_HI then LEN_LO: capture 16-bit length N in words, big-endian.
  - N==0: go to DONE, no writes.
  - N>2**ADDR_W: go to ERR, no writes.
- BYTE_HI captures wdata[15:8]; BYTE_LO captures wdata[7:0], then goes to WRITE.
- WRITE lasts exactly one cycle:
  - mem_we=1, mem_addr=(BASE_ADDR+idx) mod 2**ADDR_W, mem_wdata stable for the full cycle, so the memory's negedge write captures it.
  - Next cycle: idx and word_count increment. If idx==N go to CHK or DONE, else go to BYTE_HI.
- mem_we is 0 in every state except WRITE.
- Address wrap: BASE_ADDR+idx wraps past 511 to 0. Allowed; no error.
- in_valid stalls of any length in any accepting state are tolerated; the state is held.
- DONE/ERR: cpu_hold=0; done or error is held until the next start.
- Latency:
  - each word takes at least 3 cycles (2 bytes + 1 write);
  - a back-to-back load of N words takes at least 2+3N cycles, plus 1 with checksum.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- With the macro:
  - a running XOR of every data byte, excluding the length bytes, is kept;
  - after the last word, state CHK accepts one trailing byte;
  - equal to the running XOR: go to DONE; otherwise go to ERR. The written words are not rolled back.
- Without the macro: no CHK state and no trailing byte; DONE directly after the last WRITE.

Decomposition:
- Shared package imem_loader_pkg: state enum, IMEM_ADDR_W=9, IMEM_DATA_W=16, IMEM_DEPTH=512, LEN_BYTES=2.
- No sub-module is needed. The checksum accumulator is a few inline lines under the macro.

Test Plan:
- Reset, then start, then bytes 00 02 12 34 AB CD -> writes 0x1234 at addr 0 and 0xABCD at addr 1. done=1, word_count=2, cpu_hold high from the cycle after start until DONE.
- Length 0x0000 -> done=1 with no mem_we pulse. Length 0x0201 (513) -> error=1 with no mem_we pulse.
- BASE_ADDR=510, N=4 -> writes at 510, 511, 0, 1, in order.
- Random in_valid gaps of 0-5 cycles during a 16-word load -> memory contents identical to the gap-free run; mem_we pulses exactly 16 times.
- rst asserted after 3 of 8 words -> all outputs 0 immediately, state IDLE, addrs 0-2 keep their data. A later start with a full load then succeeds.
- With IMEM_LOADER_CHECKSUM_EN: 00 01 12 34 26 -> done=1. The same stream with trailing byte 27 -> error=1 and 0x1234 remains at addr 0.
